// File: rtl/mi_shared_arbiter.sv
// mi_shared_arbiter: round-robin arbiter sharing one MI slave between MASTERS
// MI masters. Read owners are kept in an in-order ID FIFO so every DRDY/DRD
// response is routed back to the master that issued the read.
// Optional feature: define MI_ARB_TIMEOUT_EN to synthesise a response
// (DRD = 0xDEADDEAD) when a read stays unanswered for TIMEOUT_CYCLES.
module mi_shared_arbiter #(
  parameter int MASTERS        = 3,
  parameter int MI_DATA_WIDTH  = 32,
  parameter int MI_ADDR_WIDTH  = 32,
  parameter int RD_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [MASTERS*MI_DATA_WIDTH-1:0]   RX_MI_DWR,
  input  logic [MASTERS*MI_ADDR_WIDTH-1:0]   RX_MI_ADDR,
  input  logic [MASTERS*MI_DATA_WIDTH/8-1:0] RX_MI_BE,
  input  logic [MASTERS-1:0]                 RX_MI_RD,
  input  logic [MASTERS-1:0]                 RX_MI_WR,
  output logic [MASTERS-1:0]                 RX_MI_ARDY,
  output logic [MASTERS*MI_DATA_WIDTH-1:0]   RX_MI_DRD,
  output logic [MASTERS-1:0]                 RX_MI_DRDY,
  output logic [MI_DATA_WIDTH-1:0]           TX_MI_DWR,
  output logic [MI_ADDR_WIDTH-1:0]           TX_MI_ADDR,
  output logic [MI_DATA_WIDTH/8-1:0]         TX_MI_BE,
  output logic                               TX_MI_RD,
  output logic                               TX_MI_WR,
  input  logic                               TX_MI_ARDY,
  input  logic [MI_DATA_WIDTH-1:0]           TX_MI_DRD,
  input  logic                               TX_MI_DRDY,
  output logic                               ERR_UNEXP_DRDY,
  output logic                               ERR_TIMEOUT
);

  localparam int GW = $clog2(MASTERS);
  localparam int PW = $clog2(RD_OUTSTANDING);
  localparam int BW = MI_DATA_WIDTH / 8;
  localparam logic [GW-1:0] LAST_IDX   = GW'(MASTERS - 1);
  localparam logic [PW:0]   FIFO_DEPTH = (PW + 1)'(RD_OUTSTANDING);

  if (MASTERS < 2 || MASTERS > 8) begin : g_chk_masters
    $error("mi_shared_arbiter: MASTERS must be in 2..8");
  end
  if (RD_OUTSTANDING < 2 || (RD_OUTSTANDING & (RD_OUTSTANDING - 1)) != 0) begin : g_chk_depth
    $error("mi_shared_arbiter: RD_OUTSTANDING must be a power of 2, >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("mi_shared_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, rr_q, rr_d;
  logic [MASTERS-1:0]  elig;
  logic                pick_valid;
  logic [GW-1:0]       pick_idx;
  logic                g_rd, g_wr;
  logic [MI_ADDR_WIDTH-1:0] g_addr;
  logic [MI_DATA_WIDTH-1:0] g_dwr;
  logic [BW-1:0]       g_be;
  logic                push, pop;

  logic [GW-1:0]       id_mem [RD_OUTSTANDING];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         count_q;
  logic                fifo_empty, fifo_full;
  logic [GW-1:0]       head_id;

  logic                resp_valid, unexp_drdy, err_unexp_q;
  logic [MI_DATA_WIDTH-1:0] resp_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign head_id    = id_mem[rd_ptr_q];

  // A read request (even combined with a write) cannot win while the FIFO is full.
  assign elig = (RX_MI_RD | RX_MI_WR) & ~(RX_MI_RD & {MASTERS{fifo_full}});

  // Round-robin pick: first eligible index at or after rr_q, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Downward scans leave the lowest index; the at-or-after scan overrides the wrapped one.
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (elig[i] && i < int'(rr_q)) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(i);
      end
    end
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (elig[i] && i >= int'(rr_q)) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(i);
      end
    end
  end

  // Select the request fields of the currently granted master.
  always_comb begin
    g_rd   = 1'b0;
    g_wr   = 1'b0;
    g_addr = '0;
    g_dwr  = '0;
    g_be   = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (grant_q == GW'(i)) begin
        g_rd   = RX_MI_RD[i];
        g_wr   = RX_MI_WR[i];
        g_addr = RX_MI_ADDR[i*MI_ADDR_WIDTH +: MI_ADDR_WIDTH];
        g_dwr  = RX_MI_DWR[i*MI_DATA_WIDTH +: MI_DATA_WIDTH];
        g_be   = RX_MI_BE[i*BW +: BW];
      end
    end
  end

  // FSM next state, slave request outputs and per-master address-ready.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    push       = 1'b0;
    TX_MI_ADDR = '0;
    TX_MI_DWR  = '0;
    TX_MI_BE   = '0;
    TX_MI_RD   = 1'b0;
    TX_MI_WR   = 1'b0;
    RX_MI_ARDY = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        TX_MI_ADDR = g_addr;
        TX_MI_DWR  = g_dwr;
        TX_MI_BE   = g_be;
        TX_MI_RD   = g_rd;
        TX_MI_WR   = g_wr;
        for (int i = 0; i < MASTERS; i++) begin
          RX_MI_ARDY[i] = TX_MI_ARDY && (grant_q == GW'(i));
        end
        if (!g_rd && !g_wr) begin
          // Master withdrew its request: abandon the grant, keep the pointer.
          state_d = ST_IDLE;
        end else if (TX_MI_ARDY) begin
          push    = g_rd;
          rr_d    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Outstanding-read FIFO pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage holding the owner index of each outstanding read.
  // NOTE: the storage array has no reset; entries are only read once count_q says they are valid.
  always_ff @(posedge CLK) begin
    if (push) id_mem[wr_ptr_q] <= grant_q;
  end

`ifdef MI_ARB_TIMEOUT_EN
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REPS = (MI_DATA_WIDTH + 31) / 32;
  localparam logic [REPS*32-1:0]       DEAD_WIDE = {REPS{32'hDEADDEAD}};
  localparam logic [MI_DATA_WIDTH-1:0] DEAD_WORD = DEAD_WIDE[MI_DATA_WIDTH-1:0];

  logic [TW-1:0] tmo_cnt_q;
  logic [PW:0]   tmo_pend_q;
  logic          err_tmo_q, discard, real_route, fire;

  // Late responses of timed-out reads are swallowed before any routing.
  assign discard    = TX_MI_DRDY & (tmo_pend_q != '0);
  assign real_route = TX_MI_DRDY & ~discard & ~fifo_empty;
  assign unexp_drdy = TX_MI_DRDY & ~discard & fifo_empty;
  assign fire       = ~fifo_empty & ~real_route & (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign resp_valid = real_route | fire;
  assign resp_data  = fire ? DEAD_WORD : TX_MI_DRD;
  assign ERR_TIMEOUT = err_tmo_q;

  // Head-of-FIFO wait counter and count of responses still owed by the slave.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_q  <= '0;
      tmo_pend_q <= '0;
      err_tmo_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= (pop || fifo_empty) ? '0 : tmo_cnt_q + 1'b1;
      case ({fire, discard})
        2'b10:   tmo_pend_q <= tmo_pend_q + 1'b1;
        2'b01:   tmo_pend_q <= tmo_pend_q - 1'b1;
        default: tmo_pend_q <= tmo_pend_q;
      endcase
      if (fire) err_tmo_q <= 1'b1;
    end
  end
`else
  assign unexp_drdy  = TX_MI_DRDY & fifo_empty;
  assign resp_valid  = TX_MI_DRDY & ~fifo_empty;
  assign resp_data   = TX_MI_DRD;
  assign ERR_TIMEOUT = 1'b0;
`endif

  assign pop = resp_valid;

  // Route the response to the FIFO head owner; every other master sees zero.
  always_comb begin
    RX_MI_DRDY = '0;
    RX_MI_DRD  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (resp_valid && head_id == GW'(i)) begin
        RX_MI_DRDY[i] = 1'b1;
        RX_MI_DRD[i*MI_DATA_WIDTH +: MI_DATA_WIDTH] = resp_data;
      end
    end
  end

  // Sticky flag for a response arriving with no read outstanding.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        err_unexp_q <= 1'b0;
    else if (unexp_drdy) err_unexp_q <= 1'b1;
  end

  assign ERR_UNEXP_DRDY = err_unexp_q;

endmodule

// File: tb/tb_mi_shared_arbiter.sv
// Self-checking bench for mi_shared_arbiter (3 masters, 32-bit MI, 4 reads
// outstanding). Expected read responses are queued when reads are issued and
// compared by a monitor whenever any RX_MI_DRDY fires.
module tb_mi_shared_arbiter;

`ifdef MI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk, rst_n;
  logic [95:0] rx_dwr, rx_addr;
  logic [11:0] rx_be;
  logic [2:0]  rx_rd, rx_wr;
  logic [2:0]  rx_mi_ardy, rx_mi_drdy;
  logic [95:0] rx_mi_drd;
  logic [31:0] tx_mi_dwr, tx_mi_addr, tx_drd;
  logic [3:0]  tx_mi_be;
  logic        tx_mi_rd, tx_mi_wr, tx_ardy, tx_drdy;
  logic        err_unexp, err_tmo;

  mi_shared_arbiter #(
    .MASTERS(3), .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32),
    .RD_OUTSTANDING(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .RX_MI_DWR(rx_dwr), .RX_MI_ADDR(rx_addr), .RX_MI_BE(rx_be),
    .RX_MI_RD(rx_rd), .RX_MI_WR(rx_wr),
    .RX_MI_ARDY(rx_mi_ardy), .RX_MI_DRD(rx_mi_drd), .RX_MI_DRDY(rx_mi_drdy),
    .TX_MI_DWR(tx_mi_dwr), .TX_MI_ADDR(tx_mi_addr), .TX_MI_BE(tx_mi_be),
    .TX_MI_RD(tx_mi_rd), .TX_MI_WR(tx_mi_wr), .TX_MI_ARDY(tx_ardy),
    .TX_MI_DRD(tx_drd), .TX_MI_DRDY(tx_drdy),
    .ERR_UNEXP_DRDY(err_unexp), .ERR_TIMEOUT(err_tmo)
  );

  typedef struct {
    int          master;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int m, input logic [31:0] d);
    exp_t e;
    e.master = m;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_rd   = '0;
    rx_wr   = '0;
    rx_dwr  = '0;
    rx_addr = '0;
    rx_be   = '0;
    tx_ardy = 1'b0;
    tx_drdy = 1'b0;
    tx_drd  = '0;
    exp_q.delete();
    @(negedge clk);
    check("rst_tx_req", {tx_mi_rd, tx_mi_wr, tx_mi_addr}, '0);
    check("rst_ardy", rx_mi_ardy, '0);
    check("rst_drdy", rx_mi_drdy, '0);
    check("rst_err", {err_unexp, err_tmo}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for address-ready to master m; returns at the falling edge where it is seen.
  task automatic wait_ardy(input int m, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_mi_ardy[m]) begin
        got = 1'b1;
        break;
      end
      clk_step();
    end
    check(tag, got, 1'b1);
  endtask

  // Response monitor: every DRDY pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [2:0]  m_exp;
    logic [95:0] d_exp;
    if (rst_n && rx_mi_drdy != '0) begin
      if (exp_q.size() == 0) begin
        check("drdy_unexpected", rx_mi_drdy, '0);
      end else begin
        e     = exp_q.pop_front();
        m_exp = 3'b001 << e.master;
        d_exp = {64'b0, e.data} << (e.master * 32);
        check("drdy_master", rx_mi_drdy, m_exp);
        check("drd_route", rx_mi_drd, d_exp);
      end
    end
  end

  int   k, acc0, acc2, lat;
  logic pend, seen2;

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Single write from M1, then a DRDY with nothing outstanding.
    clk_step();
    rx_wr[1] = 1'b1;
    rx_addr[63:32] = 32'h10;
    rx_dwr[63:32]  = 32'hA5A5A5A5;
    rx_be[7:4]     = 4'hF;
    tx_ardy = 1'b1;
    @(negedge clk);
    check("wr_idle_tx", {tx_mi_rd, tx_mi_wr}, 2'b00);
    check("wr_idle_ardy", rx_mi_ardy, 3'b000);
    clk_step();
    @(negedge clk);
    check("wr_tx_req", {tx_mi_rd, tx_mi_wr}, 2'b01);
    check("wr_tx_addr", tx_mi_addr, 32'h10);
    check("wr_tx_dwr", tx_mi_dwr, 32'hA5A5A5A5);
    check("wr_tx_be", tx_mi_be, 4'hF);
    check("wr_ardy", rx_mi_ardy, 3'b010);
    clk_step();
    rx_wr = '0;
    @(negedge clk);
    check("wr_done_ardy", rx_mi_ardy, 3'b000);
    check("wr_done_tx", tx_mi_wr, 1'b0);
    clk_step();
    tx_drdy = 1'b1;
    tx_drd  = 32'h12345678;
    @(negedge clk);
    check("unexp_no_route", rx_mi_drdy, 3'b000);
    clk_step();
    tx_drdy = 1'b0;
    @(negedge clk);
    check("unexp_err_set", err_unexp, 1'b1);
    repeat (3) clk_step();
    @(negedge clk);
    check("unexp_err_sticky", err_unexp, 1'b1);

    // Round-robin fairness with all three masters reading continuously.
    do_reset();
    clk_step();
    rx_rd   = 3'b111;
    tx_ardy = 1'b1;
    k       = 0;
    pend    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rx_mi_ardy != '0) begin
        check("rr_grant", rx_mi_ardy, 3'b001 << (k % 3));
        push_exp(k % 3, 32'(32'hC0DE0000 + k));
        pend = 1'b1;
        k++;
      end
      clk_step();
      tx_drdy = pend;
      tx_drd  = 32'(32'hC0DE0000 + k - 1);
      pend    = 1'b0;
      if (k >= 6) rx_rd = '0;
    end
    check("rr_accepts", k, 6);
    check("rr_drained", exp_q.size(), 0);

    // Read routing: M2 then M0, responses returned in order.
    do_reset();
    clk_step();
    tx_ardy  = 1'b1;
    rx_rd[2] = 1'b1;
    push_exp(2, 32'h1111);
    wait_ardy(2, "rt_m2_accept");
    clk_step();
    rx_rd[2] = 1'b0;
    rx_rd[0] = 1'b1;
    push_exp(0, 32'h2222);
    wait_ardy(0, "rt_m0_accept");
    clk_step();
    rx_rd   = '0;
    tx_drdy = 1'b1;
    tx_drd  = 32'h1111;
    clk_step();
    tx_drd  = 32'h2222;
    clk_step();
    tx_drdy = 1'b0;
    @(negedge clk);
    check("rt_drained", exp_q.size(), 0);

`ifndef MI_ARB_TIMEOUT_EN
    // FIFO full: M0 keeps reading with no responses; M2 writes while reads are masked.
    do_reset();
    clk_step();
    rx_rd[0] = 1'b1;
    tx_ardy  = 1'b1;
    acc0     = 0;
    acc2     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_mi_ardy[0]) begin
        push_exp(0, 32'(32'h40000000 + acc0));
        acc0++;
      end
      seen2 = rx_mi_ardy[2];
      if (seen2) acc2++;
      clk_step();
      if (i == 10) rx_wr[2] = 1'b1;
      if (seen2)   rx_wr[2] = 1'b0;
    end
    check("full_rd_accepts", acc0, 4);
    check("full_wr_serviced", acc2, 1);
    tx_drdy = 1'b1;
    tx_drd  = 32'h40000000;
    @(negedge clk);
    check("full_pop_no_grant", rx_mi_ardy, 3'b000);
    clk_step();
    tx_drdy = 1'b0;
    @(negedge clk);
    check("full_arb_cycle", rx_mi_ardy, 3'b000);
    clk_step();
    @(negedge clk);
    check("full_regrant", rx_mi_ardy, 3'b001);
    push_exp(0, 32'h40000004);
    clk_step();
    rx_rd = '0;
    for (int j = 1; j <= 4; j++) begin
      tx_drdy = 1'b1;
      tx_drd  = 32'(32'h40000000 + j);
      clk_step();
    end
    tx_drdy = 1'b0;
    @(negedge clk);
    check("full_drained", exp_q.size(), 0);
    check("full_no_err", err_unexp, 1'b0);
`endif

    // Reset with a read outstanding: its late response becomes unexpected.
    do_reset();
    clk_step();
    tx_ardy  = 1'b1;
    rx_rd[1] = 1'b1;
    wait_ardy(1, "rst_rd_accept");
    clk_step();
    rx_rd = '0;
    @(negedge clk);
    do_reset();
    clk_step();
    tx_drdy = 1'b1;
    tx_drd  = 32'h77;
    @(negedge clk);
    check("rst_lost_drdy", rx_mi_drdy, 3'b000);
    clk_step();
    tx_drdy = 1'b0;
    @(negedge clk);
    check("rst_lost_err", err_unexp, 1'b1);

`ifdef MI_ARB_TIMEOUT_EN
    // Timeout: M1 read never answered, synthetic response, late DRDY discarded.
    do_reset();
    clk_step();
    tx_ardy  = 1'b1;
    rx_rd[1] = 1'b1;
    push_exp(1, 32'hDEADDEAD);
    wait_ardy(1, "tmo_accept");
    lat = 0;
    for (int n = 1; n <= 24; n++) begin
      clk_step();
      rx_rd = '0;
      @(negedge clk);
      if (rx_mi_drdy[1] && lat == 0) lat = n;
    end
    check("tmo_latency", lat, 16);
    check("tmo_err", err_tmo, 1'b1);
    clk_step();
    tx_drdy = 1'b1;
    tx_drd  = 32'h5555;
    @(negedge clk);
    check("tmo_late_dropped", rx_mi_drdy, 3'b000);
    clk_step();
    tx_drdy = 1'b0;
    @(negedge clk);
    check("tmo_late_not_unexp", err_unexp, 1'b0);
    check("tmo_drained", exp_q.size(), 0);
`endif

    repeat (2) clk_step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mi_shared_arbiter.md
Name: mi_shared_arbiter

Overview:
- Round-robin arbiter that shares one MI slave (PHY/PMD management space of the network module) between N MI masters, e.g. host MI, firmware MI and link-training MI.
- Serialises requests and tracks the owners of outstanding reads in an in-order ID FIFO, so each read response (DRDY/DRD) returns to the master that issued it.
- Sits between the MI splitter outputs and the MI_*_PHY / MI_*_PMD inputs of the network module.

Parameters:
- MASTERS, 3, number of MI masters (2..8)
- MI_DATA_WIDTH, 32, MI data width
- MI_ADDR_WIDTH, 32, MI address width
- RD_OUTSTANDING, 4, depth of the outstanding-read ID FIFO (power of 2, >= 2)
- TIMEOUT_CYCLES, 1024, read response timeout; used only with MI_ARB_TIMEOUT_EN

Ports:
- CLK  in  1  clock for all logic
- RESET_N  in  1  asynchronous, active-low reset
- RX_MI_DWR  in  MASTERS*MI_DATA_WIDTH  master write data, master i at slice i
- RX_MI_ADDR  in  MASTERS*MI_ADDR_WIDTH  master addresses
- RX_MI_BE  in  MASTERS*MI_DATA_WIDTH/8  master byte enables
- RX_MI_RD  in  MASTERS  read requests
- RX_MI_WR  in  MASTERS  write requests
- RX_MI_ARDY  out  MASTERS  address-ready per master
- RX_MI_DRD  out  MASTERS*MI_DATA_WIDTH  read data per master
- RX_MI_DRDY  out  MASTERS  read-data valid per master
- TX_MI_DWR  out  MI_DATA_WIDTH  slave write data
- TX_MI_ADDR  out  MI_ADDR_WIDTH  slave address
- TX_MI_BE  out  MI_DATA_WIDTH/8  slave byte enables
- TX_MI_RD  out  1  slave read
- TX_MI_WR  out  1  slave write
- TX_MI_ARDY  in  1  slave accepted request
- TX_MI_DRD  in  MI_DATA_WIDTH  slave read data
- TX_MI_DRDY  in  1  slave read-data valid
- ERR_UNEXP_DRDY  out  1  sticky: DRDY received with no read outstanding
- ERR_TIMEOUT  out  1  sticky: read timed out (tied to 0 without MI_ARB_TIMEOUT_EN)

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0; FIFO empty; error flags 0.
- Eligibility: master i is eligible when RD(i) or WR(i) is asserted. A master with RD(i)=1 is masked while the FIFO is full.
- IDLE state:
  - If any master is eligible, pick the first eligible index at or after the RR pointer (wrapping) and register it as the grant.
  - Move to BUSY on the next cycle.
  - All TX_MI_* request outputs are 0 in IDLE.
  - Arbitration latency is 1 cycle.
- BUSY state:
  - TX_MI_ADDR/DWR/BE/RD/WR are driven combinationally from the granted master.
  - RX_MI_ARDY(g) = TX_MI_ARDY; all other RX_MI_ARDY are 0.
  - On TX_MI_ARDY=1: if RD, push g into the FIFO; set the RR pointer to (g+1) mod MASTERS; return to IDLE.
  - If the granted master drops both RD and WR before ARDY (protocol violation), return to IDLE with no push and no pointer change.
- RD and WR asserted together: treated as a read for FIFO purposes; both are still forwarded to the slave.
- Throughput: at most 1 accepted transaction per 2 cycles.
- Response path:
  - On TX_MI_DRDY=1 with the FIFO non-empty: RX_MI_DRDY(head)=1 and RX_MI_DRD(head)=TX_MI_DRD in the same cycle (combinational); pop the FIFO.
  - RX_MI_DRD of non-head masters is 0.
  - On DRDY with the FIFO empty: drop the response and set ERR_UNEXP_DRDY.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
- FIFO: pointer width log2(RD_OUTSTANDING); wrap-around is a natural binary overflow; occupancy counter width log2(RD_OUTSTANDING)+1.
- Reset mid-operation: all state clears immediately (asynchronous); outstanding read IDs are lost; any later DRDY sets ERR_UNEXP_DRDY.
- Writes never enter the FIFO; they are complete on ARDY.

Optional Feature:
- Macro: MI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while the FIFO is non-empty and restarts on every pop.
  - When it reaches TIMEOUT_CYCLES, the arbiter synthesises a response to the head master: RX_MI_DRDY(head)=1, DRD=32'hDEADDEAD (replicated or truncated to MI_DATA_WIDTH). It then pops the FIFO and sets ERR_TIMEOUT.
  - A count of timed-out reads is kept (width log2(RD_OUTSTANDING)+1). While the count is non-zero, the next real TX_MI_DRDY is discarded and decrements the count, instead of being routed.
- Without the macro: no counter; ERR_TIMEOUT is constant 0; a missing response stalls reads only once the FIFO fills.

Test Plan:
- Single write: M1 WR addr 0x10, data 0xA5A5A5A5, slave ARDY in BUSY → TX_MI_WR=1 with same addr/data one cycle after request; RX_MI_ARDY=3'b010 for one cycle; FIFO stays empty.
- Round-robin fairness: all 3 masters hold RD continuously, slave always ARDY=1 → grant order 0,1,2,0,1,2; each master gets 1 of every 3 accepts.
- Read routing: M2 reads, then M0 reads; slave returns DRDY with 0x1111 then 0x2222 → RX_MI_DRDY(2) with DRD=0x1111, then RX_MI_DRDY(0) with DRD=0x2222.
- FIFO full: RD_OUTSTANDING=4, slave withholds DRDY; 5 reads issued → 4 accepted, 5th masked (no grant) until one DRDY pops, then granted next cycle; a WR from another master is still serviced while reads are masked.
- Unexpected DRDY: DRDY=1 with FIFO empty → all RX_MI_DRDY=0; ERR_UNEXP_DRDY=1 and stays 1 until RESET_N=0.
- Timeout (MI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): M1 read accepted, no DRDY → 16 cycles later RX_MI_DRDY(1)=1, DRD=0xDEADDEAD, ERR_TIMEOUT=1; the late slave DRDY is discarded.
